fwd_hazard_unit: RTL and testbench



---
 rtl/iitb_pipe_pkg.sv | 23 ++
 rtl/fwd_match.sv | 61 ++++++
 rtl/fwd_hazard_unit.sv | 107 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iitb_pipe_pkg.sv
// Shared types and constants for the IITB RISC pipeline.
// Operand-select codes and the in-flight destination tracker entry.
package iitb_pipe_pkg;

  localparam int REG_W = 3;

  localparam logic [REG_W-1:0] PC_REG = 3'd7;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wr_en;
    logic             is_load;
  } trk_entry_t;

  localparam trk_entry_t TRK_BUBBLE = '0;

endpackage

// File: rtl/fwd_match.sv
// Priority compare of one RR source against the EX/MEM/WB tracker.
// Youngest matching stage wins; the PC alias is never forwarded.
module fwd_match
  import iitb_pipe_pkg::*;
#(
  parameter logic [REG_W-1:0] PC_ADDR = PC_REG
) (
  input  logic [REG_W-1:0] i_src,
  input  logic             i_use,
  input  trk_entry_t       i_ex,
  input  trk_entry_t       i_mem,
  input  trk_entry_t       i_wb,
  output logic [1:0]       o_sel,
  output logic             o_load_hit
);

  logic       w_src_ok;
  logic [2:0] w_hit;
  logic [1:0] w_sel;
  logic       w_ld;

  assign w_src_ok = i_use & (i_src != PC_ADDR);

  assign w_hit[0] = w_src_ok & i_ex.valid
                  & i_ex.wr_en
                  & (i_ex.dest == i_src);
  assign w_hit[1] = w_src_ok & i_mem.valid
                  & i_mem.wr_en
                  & (i_mem.dest == i_src);
  assign w_hit[2] = w_src_ok & i_wb.valid
                  & i_wb.wr_en
                  & (i_wb.dest == i_src);

  always_comb begin
    w_sel = FWD_RF;
    w_ld  = 1'b0;
    priority case (1'b1)
      w_hit[0]: begin
        w_sel = FWD_EX;
        w_ld  = i_ex.is_load;
      end
      w_hit[1]: begin
        w_sel = FWD_MEM;
        w_ld  = i_mem.is_load;
      end
      w_hit[2]: begin
        w_sel = FWD_WB;
        w_ld  = i_wb.is_load;
      end
      default: begin
        w_sel = FWD_RF;
        w_ld  = 1'b0;
      end
    endcase
  end

  // Only a load still in EX has no result yet.
  assign o_sel      = w_sel;
  assign o_load_hit = (w_sel == FWD_EX) & w_ld;

endmodule

// File: rtl/fwd_hazard_unit.sv
// RR-stage operand forwarding and load-use stall controller.
// Tracks EX/MEM/WB destinations and counts stall cycles.
module fwd_hazard_unit #(
  parameter int                    REG_ADDR_W = 3,
  parameter logic [REG_ADDR_W-1:0] PC_REG     = 3'd7,
  parameter int                    CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rr_valid,
  input  logic [REG_ADDR_W-1:0] rr_src_a,
  input  logic [REG_ADDR_W-1:0] rr_src_b,
  input  logic                  rr_use_a,
  input  logic                  rr_use_b,
  input  logic [REG_ADDR_W-1:0] rr_dest,
  input  logic                  rr_wr_en,
  input  logic                  rr_is_load,
  input  logic                  flush,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  import iitb_pipe_pkg::*;

  trk_entry_t       r_ex;
  trk_entry_t       r_mem;
  trk_entry_t       r_wb;
  trk_entry_t       w_new;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_ld_a;
  logic       w_ld_b;
  logic       w_stall;
  logic       w_issue;

  fwd_match #(
    .PC_ADDR (PC_REG)
  ) u_match_a (
    .i_src      (rr_src_a),
    .i_use      (rr_use_a),
    .i_ex       (r_ex),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_sel      (w_sel_a),
    .o_load_hit (w_ld_a)
  );

  fwd_match #(
    .PC_ADDR (PC_REG)
  ) u_match_b (
    .i_src      (rr_src_b),
    .i_use      (rr_use_b),
    .i_ex       (r_ex),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_sel      (w_sel_b),
    .o_load_hit (w_ld_b)
  );

  assign w_stall = rr_valid & ~flush
                 & (w_ld_a | w_ld_b);
  assign w_issue = rr_valid & ~w_stall
                 & ~flush;

  // A stalled operand has no usable source yet.
  assign fwd_sel_a = (w_stall & w_ld_a)
                   ? FWD_RF : w_sel_a;
  assign fwd_sel_b = (w_stall & w_ld_b)
                   ? FWD_RF : w_sel_b;
  assign stall     = w_stall;
  assign stall_cnt = r_cnt;

  always_comb begin
    w_new = TRK_BUBBLE;
    if (w_issue) begin
      w_new.valid   = 1'b1;
      w_new.dest    = rr_dest;
      w_new.wr_en   = rr_wr_en;
      w_new.is_load = rr_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex  <= TRK_BUBBLE;
      r_mem <= TRK_BUBBLE;
      r_wb  <= TRK_BUBBLE;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed hazards then random traffic.
// A list-of-in-flight-instructions model predicts every cycle's outputs.
module tb_fwd_hazard_unit;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rr_valid;
  logic [2:0]    rr_src_a;
  logic [2:0]    rr_src_b;
  logic          rr_use_a;
  logic          rr_use_b;
  logic [2:0]    rr_dest;
  logic          rr_wr_en;
  logic          rr_is_load;
  logic          flush;
  logic [1:0]    fwd_sel_a;
  logic [1:0]    fwd_sel_b;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rr_valid   (rr_valid),
    .rr_src_a   (rr_src_a),
    .rr_src_b   (rr_src_b),
    .rr_use_a   (rr_use_a),
    .rr_use_b   (rr_use_b),
    .rr_dest    (rr_dest),
    .rr_wr_en   (rr_wr_en),
    .rr_is_load (rr_is_load),
    .flush      (flush),
    .fwd_sel_a  (fwd_sel_a),
    .fwd_sel_b  (fwd_sel_b),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  typedef struct {
    bit v;
    int d;
    bit we;
    bit ld;
  } ent_t;

  typedef struct {
    logic [1:0]    a;
    logic [1:0]    b;
    logic          st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  ent_t pipe[3];
  int   mcnt;
  int   checks = 0;
  int   errors = 0;
  bit   last_stall;
  bit   done = 1'b0;

  // Stage number of the youngest in-flight writer of src (0 = none).
  function automatic int sel_of(int src, bit use_it);
    if (!use_it || src == 7) return 0;
    for (int i = 0; i < 3; i++)
      if (pipe[i].v && pipe[i].we && pipe[i].d == src)
        return i + 1;
    return 0;
  endfunction

  task automatic drive(input bit v, input int sa, input int sb,
                       input bit ua, input bit ub, input int d,
                       input bit we, input bit ld, input bit fl,
                       input bit rs);
    exp_t e;
    int   ea;
    int   eb;
    bit   ha;
    bit   hb;
    bit   st;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] vd;
    va = sa;
    vb = sb;
    vd = d;
    rr_valid   = v;
    rr_src_a   = va[2:0];
    rr_src_b   = vb[2:0];
    rr_use_a   = ua;
    rr_use_b   = ub;
    rr_dest    = vd[2:0];
    rr_wr_en   = we;
    rr_is_load = ld;
    flush      = fl;
    rst        = rs;
    ea = sel_of(sa, ua);
    eb = sel_of(sb, ub);
    ha = (ea == 1) && pipe[0].ld;
    hb = (eb == 1) && pipe[0].ld;
    st = v && !fl && (ha || hb);
    if (st && ha) ea = 0;
    if (st && hb) eb = 0;
    e.a   = 2'(ea);
    e.b   = 2'(eb);
    e.st  = st;
    e.cnt = CW'(mcnt);
    q.push_back(e);
    last_stall = st;
    if (rs) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
      mcnt = 0;
    end else begin
      if (st && mcnt < CMAX) mcnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (v && !st && !fl) pipe[0] = '{1, d, we, ld};
      else pipe[0] = '{0, 0, 0, 0};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input int d, input int a, input int b);
    drive(1, a, b, 1, 1, d, 1, 0, 0, 0);
  endtask

  task automatic lw(input int d, input int a);
    drive(1, a, 0, 1, 0, d, 1, 1, 0, 0);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", n, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fwd_sel_a", 32'(fwd_sel_a), 32'(e.a));
        chk("fwd_sel_b", 32'(fwd_sel_b), 32'(e.b));
        chk("stall", 32'(stall), 32'(e.st));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bit v, ua, ub, we, ld, fl, rs;
    int sa, sb, d;
    rst = 1'b1;
    rr_valid = 0; rr_src_a = 0; rr_src_b = 0;
    rr_use_a = 0; rr_use_b = 0; rr_dest = 0;
    rr_wr_en = 0; rr_is_load = 0; flush = 0;
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    mcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: a dependent-looking RR still gets zeros.
    alu(1, 1, 1);
    // ALU -> ALU back-to-back.
    alu(1, 2, 3);
    alu(2, 1, 3);
    nop(); nop(); nop();
    // Load-use: one stall, then MEM forwarding.
    lw(4, 0);
    alu(5, 4, 4);
    alu(5, 4, 4);
    nop(); nop(); nop();
    // R3 in EX, MEM and WB: youngest wins.
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    alu(6, 0, 3);
    nop(); nop(); nop();
    // PC alias and unused source never forward.
    alu(7, 1, 1);
    alu(1, 7, 7);
    alu(6, 1, 1);
    drive(1, 6, 6, 0, 1, 2, 1, 0, 0, 0);
    nop(); nop(); nop();
    // Flush overrides load-use stall.
    lw(4, 0);
    drive(1, 4, 4, 1, 1, 5, 1, 0, 1, 0);
    alu(6, 5, 4);
    nop(); nop(); nop();
    // Counter saturation.
    repeat (600) lw(4, 4);
    alu(1, 4, 4);
    // Reset mid-stream.
    lw(4, 0);
    drive(1, 4, 4, 1, 1, 5, 1, 0, 0, 1);
    alu(5, 4, 4);
    alu(2, 5, 4);
    // Random traffic; RR held while stalled.
    v = 1; sa = 0; sb = 0; ua = 0; ub = 0;
    d = 0; we = 0; ld = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!last_stall) begin
        v  = ($urandom_range(0, 7) != 0);
        sa = $urandom_range(0, 7);
        sb = $urandom_range(0, 7);
        ua = $urandom_range(0, 3) != 0;
        ub = $urandom_range(0, 3) != 0;
        d  = $urandom_range(0, 7);
        we = $urandom_range(0, 4) != 0;
        ld = $urandom_range(0, 2) == 0;
      end
      fl = $urandom_range(0, 7) == 0;
      rs = $urandom_range(0, 63) == 0;
      drive(v, sa, sb, ua, ub, d, we, ld, fl, rs);
    end
    nop();
    done = 1'b1;
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
